// File: rtl/gate_pkg.sv
// gate_pkg: shared definitions for the gate_sched block.
//   OP_NOT/OP_AND/OP_OR/OP_XOR : 2-bit opcodes for logic_unit
//   state_t                    : scheduler FSM encoding (IDLE, EXEC, DONE)
package gate_pkg;

    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gate_sched_logic_unit.sv
// logic_unit: combinational bitwise operation evaluator shared by all requesters.
//   op : opcode (NOT/AND/OR/XOR)
//   a  : operand A
//   b  : operand B (ignored for NOT)
//   y  : result
module logic_unit
    import gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/gate_sched.sv
// gate_sched: round-robin scheduler granting NREQ requesters access to one
// shared logic_unit. One operation takes three cycles (IDLE grant, EXEC
// compute, DONE complete); done pulses in the cycle after DONE.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   req  : per-requester level request, held until its done pulse
//   op   : per-requester opcode, slice i = op[2i+1:2i]
//   a, b : per-requester operands, slice i = [WIDTH*i +: WIDTH]
//   gnt  : one-hot grant, high in EXEC and DONE
//   done : one-hot one-cycle completion pulse
//   y    : registered result, valid while done is high
//   busy : state is not IDLE
module gate_sched
    import gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [2*NREQ-1:0]     op,
    input  logic [WIDTH*NREQ-1:0] a,
    input  logic [WIDTH*NREQ-1:0] b,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      y,
    output logic                  busy
);

    localparam int          IDXW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NREQ_U = NREQ;

    state_t            state;
    logic [IDXW-1:0]   last;
    logic [IDXW-1:0]   cur;
    logic [1:0]        lat_op;
    logic [WIDTH-1:0]  lat_a;
    logic [WIDTH-1:0]  lat_b;
    logic [WIDTH-1:0]  lu_y;

    logic              found;
    logic [IDXW-1:0]   win;
    logic [IDXW:0]     sum;

    // Round-robin search from last+1, wrapping. sum is one bit wider than an
    // index so last+i never overflows before the single conditional wrap.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int unsigned i = 1; i <= NREQ_U; i++) begin
            sum = {1'b0, last} + (IDXW+1)'(i);
            if (sum >= (IDXW+1)'(NREQ))
                sum = sum - (IDXW+1)'(NREQ);
            if (!found && req[sum[IDXW-1:0]]) begin
                found = 1'b1;
                win   = sum[IDXW-1:0];
            end
        end
    end

    logic_unit #(
        .WIDTH (WIDTH)
    ) u_logic_unit (
        .op (lat_op),
        .a  (lat_a),
        .b  (lat_b),
        .y  (lu_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            gnt    <= '0;
            done   <= '0;
            y      <= '0;
            last   <= IDXW'(NREQ - 1);
            cur    <= '0;
            lat_op <= '0;
            lat_a  <= '0;
            lat_b  <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        cur    <= win;
                        lat_op <= op[2*32'(win) +: 2];
                        lat_a  <= a[WIDTH*32'(win) +: WIDTH];
                        lat_b  <= b[WIDTH*32'(win) +: WIDTH];
                        gnt    <= NREQ'(1) << win;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    y     <= lu_y;
                    state <= DONE;
                end
                DONE: begin
                    done  <= NREQ'(1) << cur;
                    last  <= cur;
                    gnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
